alu_issue_ctrl: RTL and testbench

//   Issue/writeback controller that drives the 32-bit ALU (ports a, b, operation; returns result, carry).

---
 rtl/alu_issue_ctrl_if.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 72 +++++++
 tb/tb_alu_issue_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, ALU and writeback channels of the ALU issue controller
interface alu_issue_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             instr_valid;
   logic             instr_ready;
   logic [31:0]      instr;
   logic [31:0]      rs1_data;
   logic [31:0]      rs2_data;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [2:0]       alu_op;
   logic [31:0]      alu_result;
   logic             alu_carry;
   logic             wb_valid;
   logic             wb_ready;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic             wb_carry;
   logic             wb_we;
   logic             wb_illegal;
   logic [CNT_W-1:0] retire_cnt;
   modport slave (
      input  instr_valid, instr, rs1_data, rs2_data, alu_result, alu_carry, wb_ready,
      output instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, wb_carry,
             wb_we, wb_illegal, retire_cnt
   );
   modport master (
      output instr_valid, instr, rs1_data, rs2_data, alu_result, alu_carry, wb_ready,
      input  instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, wb_carry,
             wb_we, wb_illegal, retire_cnt
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes RV32I ALU instructions, issues them to the ALU and returns results on a writeback channel
module alu_issue_ctrl #(
   parameter int         CNT_W      = 16,
   parameter logic [2:0] ILLEGAL_OP = 3'b111
) (
   input logic clk,
   input logic rst_n,
   alu_issue_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [6:0]       opc, f7;
   logic [2:0]       f3, base, op;
   logic             is_r, is_i, f3_ok, legal, acc;
   logic [31:0]      imm;
   always_comb begin
      opc   = bus.instr[6:0];
      f3    = bus.instr[14:12];
      f7    = bus.instr[31:25];
      is_r  = opc == 7'b0110011;
      is_i  = opc == 7'b0010011;
      f3_ok = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b100;
      base  = f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 : f3 == 3'b100 ? 3'b100 : 3'b000;
      legal = f3_ok && (is_i || (is_r && (f7 == 7'b0000000 || (f3 == 3'b000 && f7 == 7'b0100000))));
      op    = !legal ? ILLEGAL_OP : (is_r && f7[5]) ? 3'b001 : base;
      imm   = {{20{bus.instr[31]}}, bus.instr[31:20]};
      acc   = bus.instr_valid && bus.instr_ready;
   end
   assign bus.instr_ready = state == IDLE || (state == WB && bus.wb_ready);
   assign bus.retire_cnt  = cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_op     <= '0;
         bus.wb_valid   <= 1'b0;
         bus.wb_rd      <= '0;
         bus.wb_data    <= '0;
         bus.wb_carry   <= 1'b0;
         bus.wb_we      <= 1'b0;
         bus.wb_illegal <= 1'b0;
         cnt            <= '0;
      end else begin
         // acc is only possible in IDLE or in WB while the result is being consumed
         if (acc) begin
            bus.alu_a      <= bus.rs1_data;
            bus.alu_b      <= is_r ? bus.rs2_data : imm;
            bus.alu_op     <= op;
            bus.wb_rd      <= bus.instr[11:7];
            bus.wb_illegal <= !legal;
            bus.wb_we      <= legal && bus.instr[11:7] != 5'd0;
         end
         unique case (state)
            IDLE: if (acc) state <= EXEC;
            EXEC: begin
               bus.wb_data  <= bus.wb_illegal ? 32'd0 : bus.alu_result;
               bus.wb_carry <= !bus.wb_illegal && bus.alu_carry;
               bus.wb_valid <= 1'b1;
               state        <= WB;
            end
            WB: if (bus.wb_ready) begin
               bus.wb_valid <= 1'b0;
               if (!bus.wb_illegal) cnt <= cnt + CNT_W'(1);
               state <= bus.instr_valid ? EXEC : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench with a behavioural 32-bit ALU attached
module tb_alu_issue_ctrl;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_cnt = 0;
   alu_issue_ctrl_if #(.CNT_W(W)) bus ();
   alu_issue_ctrl #(.CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   always_comb begin
      {bus.alu_carry, bus.alu_result} = 33'd0;
      case (bus.alu_op)
         3'b000: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         3'b001: {bus.alu_carry, bus.alu_result} = {bus.alu_a < bus.alu_b, bus.alu_a - bus.alu_b};
         3'b010: bus.alu_result = bus.alu_a & bus.alu_b;
         3'b011: bus.alu_result = bus.alu_a | bus.alu_b;
         3'b100: bus.alu_result = bus.alu_a ^ bus.alu_b;
         default: bus.alu_result = 32'd0;
      endcase
   end
   function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input string tag, input logic [31:0] ins, a, b, exp_b, exp_d,
                        input logic [2:0] op, input logic c, we, ill, input logic [4:0] rd);
      bus.instr = ins;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.instr_valid = 1'b1;
      bus.wb_ready = 1'b0;
      chk({tag, "/ready"}, 32'(bus.instr_ready), 32'd1);
      tick();
      bus.instr_valid = 1'b0;
      chk({tag, "/op"}, 32'(bus.alu_op), 32'(op));
      chk({tag, "/a"}, bus.alu_a, a);
      chk({tag, "/b"}, bus.alu_b, exp_b);
      chk({tag, "/valid_exec"}, 32'(bus.wb_valid), 32'd0);
      chk({tag, "/ready_exec"}, 32'(bus.instr_ready), 32'd0);
      tick();
      chk({tag, "/valid_wb"}, 32'(bus.wb_valid), 32'd1);
      chk({tag, "/data"}, bus.wb_data, exp_d);
      chk({tag, "/carry"}, 32'(bus.wb_carry), 32'(c));
      chk({tag, "/rd"}, 32'(bus.wb_rd), 32'(rd));
      chk({tag, "/we"}, 32'(bus.wb_we), 32'(we));
      chk({tag, "/illegal"}, 32'(bus.wb_illegal), 32'(ill));
      bus.wb_ready = 1'b1;
      tick();
      bus.wb_ready = 1'b0;
      if (!ill) exp_cnt++;
      chk({tag, "/cnt"}, 32'(bus.retire_cnt), 32'(exp_cnt % 256));
      chk({tag, "/valid_done"}, 32'(bus.wb_valid), 32'd0);
   endtask
   initial begin
      rst_n = 1'b0;
      bus.instr_valid = 1'b0;
      bus.wb_ready = 1'b0;
      bus.instr = '0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      #12;
      chk("rst/valid", 32'(bus.wb_valid), 32'd0);
      chk("rst/a", bus.alu_a, 32'd0);
      chk("rst/op", 32'(bus.alu_op), 32'd0);
      chk("rst/data", bus.wb_data, 32'd0);
      chk("rst/cnt", 32'(bus.retire_cnt), 32'd0);
      chk("rst/ready", 32'(bus.instr_ready), 32'd1);
      rst_n = 1'b1;
      tick();
      issue("add", rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, 32'd7, 32'd12, 3'b000, 1'b0, 1'b1, 1'b0, 5'd3);
      issue("sub", rt(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF, 3'b001, 1'b1, 1'b1, 1'b0, 5'd4);
      issue("addi", it(12'hFFF, 5'd1, 3'b000, 5'd5), 32'd1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd0, 3'b000, 1'b1, 1'b1, 1'b0, 5'd5);
      issue("xori", it(12'h800, 5'd1, 3'b100, 5'd6), 32'h0000_00FF, 32'd0, 32'hFFFF_F800, 32'hFFFF_F8FF, 3'b100, 1'b0, 1'b1, 1'b0, 5'd6);
      issue("and", rt(7'h00, 5'd2, 5'd1, 3'b111, 5'd7), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFF00_FF00, 32'hF000_F000, 3'b010, 1'b0, 1'b1, 1'b0, 5'd7);
      issue("ori", it(12'h0F0, 5'd1, 3'b110, 5'd8), 32'h0000_0F00, 32'd0, 32'h0000_00F0, 32'h0000_0FF0, 3'b011, 1'b0, 1'b1, 1'b0, 5'd8);
      issue("add_ovf", rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd13), 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 3'b000, 1'b1, 1'b1, 1'b0, 5'd13);
      issue("add_x0", rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 32'd2, 32'd3, 32'd3, 32'd5, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
      issue("slt", rt(7'h00, 5'd2, 5'd1, 3'b010, 5'd9), 32'd1, 32'd4, 32'd4, 32'd0, 3'b111, 1'b0, 1'b0, 1'b1, 5'd9);
      issue("mul", rt(7'h01, 5'd2, 5'd1, 3'b000, 5'd10), 32'd3, 32'd4, 32'd4, 32'd0, 3'b111, 1'b0, 1'b0, 1'b1, 5'd10);
      // backpressure: payload must hold and a presented instruction must be ignored
      bus.instr = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd11);
      bus.rs1_data = 32'd10;
      bus.rs2_data = 32'd20;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr = rt(7'h20, 5'd2, 5'd1, 3'b000, 5'd12);
      bus.rs1_data = 32'd9;
      bus.rs2_data = 32'd4;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp/valid", 32'(bus.wb_valid), 32'd1);
         chk("bp/data", bus.wb_data, 32'd30);
         chk("bp/rd", 32'(bus.wb_rd), 32'd11);
         chk("bp/ready", 32'(bus.instr_ready), 32'd0);
         chk("bp/a", bus.alu_a, 32'd10);
         tick();
      end
      bus.wb_ready = 1'b1;
      #1;
      chk("b2b/ready", 32'(bus.instr_ready), 32'd1);
      tick();
      exp_cnt++;
      bus.instr_valid = 1'b0;
      bus.wb_ready = 1'b0;
      chk("b2b/valid_exec", 32'(bus.wb_valid), 32'd0);
      chk("b2b/op", 32'(bus.alu_op), 32'd1);
      chk("b2b/a", bus.alu_a, 32'd9);
      chk("b2b/cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
      tick();
      chk("b2b/data", bus.wb_data, 32'd5);
      chk("b2b/rd", 32'(bus.wb_rd), 32'd12);
      bus.wb_ready = 1'b1;
      tick();
      bus.wb_ready = 1'b0;
      exp_cnt++;
      chk("b2b/cnt2", 32'(bus.retire_cnt), 32'(exp_cnt));
      // reset during EXEC discards the instruction
      bus.instr = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd14);
      bus.rs1_data = 32'd100;
      bus.rs2_data = 32'd1;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
      chk("mid/a", bus.alu_a, 32'd100);
      rst_n = 1'b0;
      #1;
      chk("mid/valid", 32'(bus.wb_valid), 32'd0);
      chk("mid/a0", bus.alu_a, 32'd0);
      chk("mid/data", bus.wb_data, 32'd0);
      chk("mid/rd", 32'(bus.wb_rd), 32'd0);
      chk("mid/cnt", 32'(bus.retire_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      tick();
      tick();
      chk("mid/valid_after", 32'(bus.wb_valid), 32'd0);
      // streaming retires to reach the counter wrap
      bus.instr = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd1);
      bus.instr_valid = 1'b1;
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 511; i++) tick();
      chk("wrap/max", 32'(bus.retire_cnt), 32'hFF);
      bus.instr_valid = 1'b0;
      tick();
      chk("wrap/valid", 32'(bus.wb_valid), 32'd1);
      tick();
      chk("wrap/zero", 32'(bus.retire_cnt), 32'd0);
      chk("wrap/idle", 32'(bus.wb_valid), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
